// File: rtl/data_mem_responder.sv
// Responder side of the multicycle core's memory request interface.
// It accepts one MemRead/MemWrite request at a time and waits a fixed number
// of cycles. It then answers with a one-cycle Ready pulse. Loads use
// little-endian byte/half/word lanes with sign or zero extension. Misaligned,
// out-of-range, reserved-size and conflicting requests are flagged on AddrErr.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic [31:0] RData,
  output logic        Ready,
  output logic        AddrErr,
  output logic        Busy
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic          wr_q, wr_d;
  logic          both_q, both_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  // While idle the request on the inputs is the one being accepted. Otherwise
  // the latched copy is used, so that input changes in WAIT/RESP have no effect.
  logic          idle;
  logic [31:0]   acc_addr;
  logic [1:0]    acc_size;
  logic          acc_sext, acc_wr, acc_both, acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rd_word, load_val;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          mem_we;

  assign idle     = (state_q == ST_IDLE);
  assign acc_addr = idle ? Addr : addr_q;
  assign acc_size = idle ? Size : size_q;
  assign acc_sext = idle ? SignExt : sext_q;
  assign acc_wr   = idle ? MemWrite : wr_q;
  assign acc_both = idle ? (MemRead & MemWrite) : both_q;
  assign acc_idx  = acc_addr[AW+1:2];
  assign rd_word  = mem[acc_idx];

  // Error qualifier for the access being accepted or serviced
  always_comb begin
    acc_err = acc_both
            | (acc_size == 2'b11)
            | ((acc_size == 2'b01) && acc_addr[0])
            | ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00))
            | ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
  end

  // Lane select and sign/zero extension of the load data
  always_comb begin
    lane_b   = 8'h00;
    lane_h   = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    case (acc_addr[1:0])
      2'd0:    lane_b = rd_word[7:0];
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    case (acc_size)
      2'b00:   load_val = acc_sext ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      2'b01:   load_val = acc_sext ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: load_val = rd_word;
    endcase
  end

  // Next-state logic: request capture, wait countdown, response data
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wr_d    = wr_q;
    both_d  = both_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (MemRead | MemWrite) begin
          addr_d  = Addr;
          wdata_d = WData;
          size_d  = Size;
          sext_d  = SignExt;
          wr_d    = MemWrite;
          both_d  = MemRead & MemWrite;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_LD == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
    // RData is captured only on entry to RESP and then holds.
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      rdata_d = (!acc_wr && !acc_err) ? load_val : 32'h0;
    end
  end

  // State and latched-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte enables and lane-replicated store data for the committing write
  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (size_q)
      2'b00:   wlane = {4{wdata_q[7:0]}};
      2'b01:   wlane = {2{wdata_q[15:0]}};
      default: wlane = wdata_q;
    endcase
  end

  // A write commits on the edge that ends RESP. Reset forces IDLE, so an
  // abandoned write never reaches this point.
  assign mem_we = (state_q == ST_RESP) && wr_q && !acc_err;

  // RAM write port with per-byte enables
  // NOTE: the RAM array is deliberately left without reset; its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[acc_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign RData   = rdata_q;
  assign Ready   = (state_q == ST_RESP);
  assign AddrErr = Ready & acc_err;
  assign Busy    = !idle;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. It uses three instances with
// WAIT_CYCLES of 2, 0 and 3. Expected responses are queued when a request is
// driven. They are popped and compared when Ready pulses.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [1:0]  size      [3];
  logic        sign_ext  [3];
  logic [31:0] rdata     [3];
  logic        ready     [3];
  logic        addr_err  [3];
  logic        busy      [3];

  int wait_c [3] = '{2, 0, 3};

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .Addr(addr[0]), .WData(wdata[0]), .Size(size[0]), .SignExt(sign_ext[0]),
    .RData(rdata[0]), .Ready(ready[0]), .AddrErr(addr_err[0]), .Busy(busy[0]));

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .Addr(addr[1]), .WData(wdata[1]), .Size(size[1]), .SignExt(sign_ext[1]),
    .RData(rdata[1]), .Ready(ready[1]), .AddrErr(addr_err[1]), .Busy(busy[1]));

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
    .Addr(addr[2]), .WData(wdata[2]), .Size(size[2]), .SignExt(sign_ext[2]),
    .RData(rdata[2]), .Ready(ready[2]), .AddrErr(addr_err[2]), .Busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drives one request on instance d and waits for Ready. If scramble is set,
  // the request inputs are changed during WAIT to alt_addr.
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic se,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input string tag,
                        input bit scramble = 1'b0, input logic [31:0] alt_addr = 32'h0);
    exp_t e;
    int   n;
    bit   got;
    sb_q.push_back('{tag, exp_rd, exp_err, wait_c[d] + 1});
    @(negedge clk);
    mem_read[d]  = rd;
    mem_write[d] = wr;
    addr[d]      = a;
    wdata[d]     = wd;
    size[d]      = sz;
    sign_ext[d]  = se;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ready[d]) got = 1'b1;
      else if (scramble && n == 1) begin
        addr[d]     = alt_addr;
        wdata[d]    = ~wd;
        sign_ext[d] = ~se;
      end
    end
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    e = sb_q.pop_front();
    if (!got) begin
      check({e.tag, "_timeout"}, 32'(got), 32'd1);
      return;
    end
    check({e.tag, "_lat"},   32'(n), 32'(e.lat));
    check({e.tag, "_rdata"}, rdata[d], e.rdata);
    check({e.tag, "_err"},   32'(addr_err[d]), 32'(e.err));
    check({e.tag, "_busy"},  32'(busy[d]), 32'd1);
    @(posedge clk);
    #1;
    check({e.tag, "_pulse"}, {30'h0, ready[d], addr_err[d]}, 32'h0);
  endtask

  initial begin
    bit ready_seen;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; addr[i] = 32'h0;
      wdata[i] = 32'h0;   size[i] = 2'b10;    sign_ext[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata[0], 32'h0);
    check("reset_flags", {29'h0, ready[0], addr_err[0], busy[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store and load with WAIT_CYCLES=2
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, "sw_deadbeef");
    access(0, 1, 0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0, "lw_deadbeef");

    // Byte/half loads with extension
    access(0, 0, 1, 32'h10, 32'h80FF7F01, 2'b10, 0, 32'h0,        0, "sw_80ff7f01");
    access(0, 1, 0, 32'h12, 32'h0,        2'b00, 1, 32'hFFFFFFFF, 0, "lb_12");
    access(0, 1, 0, 32'h13, 32'h0,        2'b00, 0, 32'h00000080, 0, "lbu_13");
    access(0, 1, 0, 32'h12, 32'h0,        2'b01, 1, 32'hFFFF80FF, 0, "lh_12");
    access(0, 1, 0, 32'h10, 32'h0,        2'b01, 0, 32'h00007F01, 0, "lhu_10");
    access(0, 1, 0, 32'h10, 32'h0,        2'b00, 1, 32'h00000001, 0, "lb_10_pos");
    access(0, 1, 0, 32'h11, 32'h0,        2'b10, 1, 32'h0,        1, "lw_11_mis");

    // Byte/half stores
    access(0, 0, 1, 32'h10, 32'h11223344, 2'b10, 0, 32'h0,        0, "sw_11223344");
    access(0, 0, 1, 32'h11, 32'h000000AA, 2'b00, 0, 32'h0,        0, "sb_11");
    access(0, 1, 0, 32'h10, 32'h0,        2'b10, 0, 32'h1122AA44, 0, "lw_after_sb");
    access(0, 0, 1, 32'h12, 32'hFFFF5566, 2'b01, 0, 32'h0,        0, "sh_12");
    access(0, 1, 0, 32'h10, 32'h0,        2'b10, 0, 32'h5566AA44, 0, "lw_after_sh");

    // Error cases: reads return 0, writes must not touch memory
    access(0, 1, 0, 32'h13,   32'h0,      2'b10, 0, 32'h0, 1, "err_lw_13");
    access(0, 1, 0, 32'h10,   32'h0,      2'b10, 0, 32'h5566AA44, 0, "lw_reload");
    access(0, 1, 0, 32'h01,   32'h0,      2'b01, 1, 32'h0, 1, "err_lh_01");
    access(0, 1, 0, 32'h10,   32'h0,      2'b11, 0, 32'h0, 1, "err_size11");
    access(0, 1, 0, 32'h1000, 32'h0,      2'b10, 0, 32'h0, 1, "err_range");
    access(0, 1, 1, 32'h10,   32'h0,      2'b10, 0, 32'h0, 1, "err_rd_wr");
    access(0, 0, 1, 32'h12,   32'h0,      2'b10, 0, 32'h0, 1, "err_sw_12");
    access(0, 0, 1, 32'h11,   32'h0,      2'b01, 0, 32'h0, 1, "err_sh_11");
    access(0, 0, 1, 32'h10,   32'h0,      2'b11, 0, 32'h0, 1, "err_s_sz11");
    access(0, 1, 0, 32'h10,   32'h0,      2'b10, 0, 32'h5566AA44, 0, "lw_unchanged");

    // Reset during WAIT abandons a pending write
    access(0, 0, 1, 32'h20, 32'h0, 2'b10, 0, 32'h0, 0, "sw_20_zero");
    @(negedge clk);
    mem_write[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678; size[0] = 2'b10;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    mem_write[0] = 1'b0;
    #1;
    check("abort_flags", {29'h0, ready[0], addr_err[0], busy[0]}, 32'h0);
    check("abort_rdata", rdata[0], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready[0]) ready_seen = 1'b1;
    end
    check("abort_no_ready", 32'(ready_seen), 32'd0);
    access(0, 1, 0, 32'h20, 32'h0, 2'b10, 0, 32'h0, 0, "lw_20_after_abort");

    // WAIT_CYCLES=0: Ready the cycle after acceptance, back-to-back
    access(1, 0, 1, 32'h40, 32'hCAFEF00D, 2'b10, 0, 32'h0,        0, "w0_sw");
    access(1, 1, 0, 32'h40, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0, "w0_lw");
    access(1, 1, 0, 32'h43, 32'h0,        2'b00, 1, 32'hFFFFFFCA, 0, "w0_lb");

    // WAIT_CYCLES=3: inputs changed during WAIT are ignored
    access(2, 0, 1, 32'h08, 32'h0A0B0C0D, 2'b10, 0, 32'h0,        0, "w3_sw_08");
    access(2, 0, 1, 32'h0C, 32'h11111111, 2'b10, 0, 32'h0,        0, "w3_sw_0c");
    access(2, 1, 0, 32'h08, 32'h0,        2'b10, 0, 32'h0A0B0C0D, 0, "w3_lw_scr", 1'b1, 32'h0C);
    access(2, 0, 1, 32'h08, 32'h000000EE, 2'b00, 0, 32'h0,        0, "w3_sb_scr", 1'b1, 32'h0E);
    access(2, 1, 0, 32'h0C, 32'h0,        2'b10, 0, 32'h11111111, 0, "w3_lw_0c");
    access(2, 1, 0, 32'h08, 32'h0,        2'b10, 0, 32'h0A0B0CEE, 0, "w3_lw_08");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
